colormap_ctrl: RTL

Streaming controller that sequences a bank of NMAPS combinational 256-entry false-color maps for the spectrogram display path. It accepts 8-bit log-magnitude pixels on a valid/ready stream, drives the shared map-bank index and selects one map's RGB output. Map changes, from the host or from an auto-cycle timer, take effect only at a start-of-frame beat, so no frame ever mixes colormaps. It sits between the spectrogram line buffer and the video output framer.

---
 rtl/colormap_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/colormap_ctrl.sv
// -----------------------------------------------------------------------------
// colormap_ctrl
//
// Streaming false-color controller for the spectrogram display path. Pixels
// (8-bit log magnitude) enter on S_VID, their value is driven to an external
// bank of NMAPS combinational 256-entry colormaps, and the selected map's RGB
// result leaves on M_VID two cycles later. A map change, whether written by
// the host or produced by the auto-cycle timer, is applied only on a
// start-of-frame beat. That way a frame never mixes two colormaps.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_cfg_*             host configuration write (strobe, map, auto, hold)
//   o_cfg_err           one-cycle pulse on a write naming a nonexistent map
//   o_active_map        map applied to the current frame
//   S_VID_*             input pixel stream (USER = SOF, LAST = end of line)
//   o_map_pixel         index driven to every map in the bank
//   i_map_rgb           bank outputs, map k at [24k+23:24k] as {R,G,B}
//   M_VID_*             output RGB stream
// -----------------------------------------------------------------------------
module colormap_ctrl #(
   parameter int NMAPS       = 4,
   parameter int MW          = 2,
   parameter int DEFAULT_MAP = 0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_cfg_stb,
   input  logic [MW-1:0]         i_cfg_map,
   input  logic                  i_cfg_auto,
   input  logic [7:0]            i_cfg_hold,
   output logic                  o_cfg_err,
   output logic [MW-1:0]         o_active_map,
   input  logic                  S_VID_VALID,
   output logic                  S_VID_READY,
   input  logic [7:0]            S_VID_DATA,
   input  logic                  S_VID_LAST,
   input  logic                  S_VID_USER,
   output logic [7:0]            o_map_pixel,
   input  logic [24*NMAPS-1:0]   i_map_rgb,
   output logic                  M_VID_VALID,
   input  logic                  M_VID_READY,
   output logic [23:0]           M_VID_DATA,
   output logic                  M_VID_LAST,
   output logic                  M_VID_USER
);

   localparam logic [MW-1:0] DEF_MAP = MW'(DEFAULT_MAP);

   // Stage A: pixel, sideband and the map chosen for this beat
   logic          va_q, va_d;
   logic [7:0]    pix_a_q, pix_a_d;
   logic          last_a_q, last_a_d;
   logic          user_a_q, user_a_d;
   logic [MW-1:0] map_a_q, map_a_d;

   // Stage B: selected RGB and sideband
   logic          vb_q, vb_d;
   logic [23:0]   rgb_b_q, rgb_b_d;
   logic          last_b_q, last_b_d;
   logic          user_b_q, user_b_d;

   // Map selection state
   logic [MW-1:0] active_q, active_d;
   logic [MW-1:0] pend_map_q, pend_map_d;
   logic          pend_q, pend_d;
   logic          auto_q, auto_d;
   logic [7:0]    hold_q, hold_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          err_q, err_d;

   logic          s_ready;
   logic          accept;
   logic          a_adv;
   logic          cfg_ok;

   // NOTE: every variable gets its default before any branch, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      va_d       = va_q;
      pix_a_d    = pix_a_q;
      last_a_d   = last_a_q;
      user_a_d   = user_a_q;
      map_a_d    = map_a_q;
      vb_d       = vb_q;
      rgb_b_d    = rgb_b_q;
      last_b_d   = last_b_q;
      user_b_d   = user_b_q;
      active_d   = active_q;
      pend_map_d = pend_map_q;
      pend_d     = pend_q;
      auto_d     = auto_q;
      hold_d     = hold_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;

      // Stage A can take a beat when it is empty or is emptying this cycle.
      s_ready = !i_reset && (!va_q || !vb_q || M_VID_READY);
      accept  = S_VID_VALID && s_ready;
      a_adv   = va_q && (!vb_q || M_VID_READY);
      cfg_ok  = int'(i_cfg_map) < NMAPS;

      // Frame-boundary map update, evaluated from the pre-write state so that
      // a write landing on the SOF cycle waits for the following frame.
      if (accept && S_VID_USER) begin
         if (pend_q) begin
            active_d = pend_map_q;
            pend_d   = 1'b0;
            cnt_d    = 8'd0;
         end else if (auto_q && cnt_q == hold_q) begin
            active_d = (int'(active_q) == NMAPS - 1) ? '0 : active_q + 1'b1;
            cnt_d    = 8'd0;
         end else if (auto_q) begin
            cnt_d = cnt_q + 8'd1;
         end
      end

      // Host write overrides the pending/timer state computed above.
      if (i_cfg_stb) begin
         if (cfg_ok) begin
            pend_map_d = i_cfg_map;
            pend_d     = 1'b1;
            auto_d     = i_cfg_auto;
            hold_d     = i_cfg_hold;
            cnt_d      = 8'd0;
         end else begin
            err_d = 1'b1;
         end
      end

      // Stage B loads from A, or empties once its beat is taken.
      if (a_adv) begin
         vb_d     = 1'b1;
         rgb_b_d  = i_map_rgb[24*int'(map_a_q) +: 24];
         last_b_d = last_a_q;
         user_b_d = user_a_q;
      end else if (M_VID_READY) begin
         vb_d = 1'b0;
      end

      // Stage A; the SOF beat already carries the map it switches to.
      if (accept) begin
         va_d     = 1'b1;
         pix_a_d  = S_VID_DATA;
         last_a_d = S_VID_LAST;
         user_a_d = S_VID_USER;
         map_a_d  = active_d;
      end else if (a_adv) begin
         va_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the pre-edge value of the others.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         va_q       <= 1'b0;
         pix_a_q    <= 8'd0;
         last_a_q   <= 1'b0;
         user_a_q   <= 1'b0;
         map_a_q    <= DEF_MAP;
         vb_q       <= 1'b0;
         rgb_b_q    <= 24'd0;
         last_b_q   <= 1'b0;
         user_b_q   <= 1'b0;
         active_q   <= DEF_MAP;
         pend_map_q <= DEF_MAP;
         pend_q     <= 1'b0;
         auto_q     <= 1'b0;
         hold_q     <= 8'd0;
         cnt_q      <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         va_q       <= va_d;
         pix_a_q    <= pix_a_d;
         last_a_q   <= last_a_d;
         user_a_q   <= user_a_d;
         map_a_q    <= map_a_d;
         vb_q       <= vb_d;
         rgb_b_q    <= rgb_b_d;
         last_b_q   <= last_b_d;
         user_b_q   <= user_b_d;
         active_q   <= active_d;
         pend_map_q <= pend_map_d;
         pend_q     <= pend_d;
         auto_q     <= auto_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign S_VID_READY  = s_ready;
   assign o_map_pixel  = pix_a_q;
   assign M_VID_VALID  = vb_q;
   assign M_VID_DATA   = rgb_b_q;
   assign M_VID_LAST   = last_b_q;
   assign M_VID_USER   = user_b_q;
   assign o_active_map = active_q;
   assign o_cfg_err    = err_q;

endmodule
